fifo_rd_streamer: RTL and testbench
===================================

// Module: fifo_rd_streamer
// PURPOSE
//  Read-side consumer for the async_fifo read port in the RdClock domain. Holds off
//  until the FIFO holds START_LVL words (prefill), then drains it into a valid/ready
//  output stream through a 2-entry output buffer, absorbing the FIFO's 1-cycle read
//  latency. Detects underrun, counts it, and falls back to prefill. Feeds the audio
//  playback path.
// PARAMETERS
//  DSIZE      32  data word width; matches the FIFO DSIZE
//  ASIZE      6   FIFO address width; FifoRdDataNum is ASIZE+1 bits
//  START_LVL  16  prefill threshold in words; legal range 1..2**ASIZE
// PORTS
//  RdClock        in   1          read-domain clock, rising edge
//  RPReset        in   1          reset, asynchronous, active-high; shared with FIFO read side
//  Enable         in   1          1 = run (prefill/stream), 0 = idle
//  FifoQ          in   DSIZE      FIFO read data; word popped in cycle n is valid in cycle n+1
//  FifoEmpty      in   1          FIFO Empty flag (registered)
//  FifoRdDataNum  in   ASIZE+1    FIFO read-side fill level
//  FifoRdEn       out  1          pop request to the FIFO
//  OutData        out  DSIZE      stream data (buffer head)
//  OutValid       out  1          OutData valid
//  OutReady       in   1          downstream accept; transfer = OutValid & OutReady
//  Underrun       out  1          1-cycle pulse on underrun detection
//  UnderrunCnt    out  16         saturating underrun count
//  State          out  2          0=IDLE 1=PREFILL 2=STREAM
// BEHAVIOUR
//  Reset: State=IDLE, buffer occupancy occ=0, inflight=0, FifoRdEn=0, OutValid=0,
//   OutData=0, Underrun=0, UnderrunCnt=0. All state registers async-cleared by RPReset.
//  FSM:
//   IDLE    -> PREFILL when Enable=1.
//   PREFILL -> STREAM when FifoRdDataNum >= START_LVL (unsigned, ASIZE+1 bits), Enable=1.
//   STREAM  -> PREFILL on underrun; any state -> IDLE when Enable=0 (takes priority).
//  Pops: FifoRdEn = (State==STREAM) & Enable & ~FifoEmpty &
//   ((occ + inflight - (OutValid & OutReady)) < 2). Never pops in IDLE/PREFILL.
//  inflight <= FifoRdEn each cycle; when inflight=1, FifoQ is written into buffer tail
//   at that cycle's edge. Word popped in cycle n -> OutValid earliest in cycle n+2.
//  Buffer: 2-entry FIFO, OutData = head; simultaneous write and transfer in one cycle
//   keeps occ unchanged and order preserved. occ never exceeds 2 (credit rule above).
//  Throughput: with OutReady=1 and FIFO non-empty, one transfer per cycle sustained.
//  Underrun: in STREAM with occ=0, inflight=0, FifoEmpty=1, OutReady=1 -> Underrun=1
//   for one cycle, UnderrunCnt += 1 (holds at 16'hFFFF), State -> PREFILL next cycle.
//  Enable=0: popping stops that cycle; an inflight word is still captured; buffer keeps
//   draining to downstream; no Underrun pulses in IDLE/PREFILL.
//  Transfer stall: OutValid=1 & OutReady=0 holds OutData/OutValid stable.
//  Reset mid-operation: buffer contents discarded, inflight word dropped, FSM to IDLE.
// TESTING
//  1. START_LVL=16; write 15 words, Enable=1 -> State stays PREFILL, FifoRdEn never 1;
//     16th word -> STREAM, first OutValid 2 cycles after first FifoRdEn.
//  2. 32 words 0..31, OutReady=1 -> OutData 0..31 in order, one per cycle, no gaps
//     after first word; then Underrun pulses once, UnderrunCnt=1, State=PREFILL.
//  3. OutReady toggled randomly during stream of 1000 words -> no loss/duplication,
//     occ<=2 always, OutData stable whenever OutValid=1 & OutReady=0.
//  4. Enable dropped mid-stream with inflight=1 -> that word still emitted, FifoRdEn=0
//     next cycle, State=IDLE, no Underrun; re-Enable -> PREFILL.
//  5. RPReset pulsed mid-stream (occ=2) -> OutValid=0, State=IDLE, UnderrunCnt=0 same cycle.
//  6. Force 65536 underruns -> UnderrunCnt holds 16'hFFFF, Underrun still pulses.

Source files
------------

// File: rtl/fifo_rd_streamer_if.sv
// Bundle between the read-side streamer, the async FIFO read port and the
// downstream stream consumer. master = streamer view, slave = environment view.
interface fifo_rd_streamer_if #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 6
);
  logic             Enable;
  logic [DSIZE-1:0] FifoQ;
  logic             FifoEmpty;
  logic [ASIZE:0]   FifoRdDataNum;
  logic             FifoRdEn;
  logic [DSIZE-1:0] OutData;
  logic             OutValid;
  logic             OutReady;
  logic             Underrun;
  logic [15:0]      UnderrunCnt;
  logic [1:0]       State;

  modport master (
    input  Enable, FifoQ, FifoEmpty, FifoRdDataNum, OutReady,
    output FifoRdEn, OutData, OutValid, Underrun, UnderrunCnt, State
  );

  modport slave (
    output Enable, FifoQ, FifoEmpty, FifoRdDataNum, OutReady,
    input  FifoRdEn, OutData, OutValid, Underrun, UnderrunCnt, State
  );
endinterface

// File: rtl/fifo_rd_streamer.sv
// Read-side FIFO consumer: prefill to START_LVL, then stream through a 2-entry
// buffer that hides the FIFO's 1-cycle read latency; underrun falls back to prefill.
module fifo_rd_streamer #(
  parameter int DSIZE     = 32,
  parameter int ASIZE     = 6,
  parameter int START_LVL = 16
) (
  input  logic                RdClock,
  input  logic                RPReset,
  fifo_rd_streamer_if.master  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, PREFILL = 2'd1, STREAM = 2'd2} state_e;

  localparam logic [ASIZE:0] START_W = (ASIZE+1)'(START_LVL);

  state_e                     state_q, state_d;
  logic [1:0]                 occ_q, occ_d;
  logic                       inflight_q, inflight_d;
  logic [1:0][DSIZE-1:0]      buf_q, buf_d;
  logic [15:0]                ucnt_q, ucnt_d;

  logic       xfer, pop, underrun;
  logic [2:0] credit;
  logic [1:0] wr_slot;

  // Credit counts the buffer entries already committed (held + in flight)
  // after this cycle's transfer, so a pop never lands on a full buffer.
  always_comb begin
    xfer     = (occ_q != 2'd0) & bus.OutReady;
    credit   = 3'(occ_q) + 3'(inflight_q) - 3'(xfer);
    pop      = (state_q == STREAM) & bus.Enable & ~bus.FifoEmpty & (credit < 3'd2);
    underrun = (state_q == STREAM) & bus.Enable & (occ_q == 2'd0) & ~inflight_q &
               bus.FifoEmpty & bus.OutReady;
  end

  always_comb begin
    state_d = state_q;
    if (!bus.Enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = PREFILL;
        PREFILL: if (bus.FifoRdDataNum >= START_W) state_d = STREAM;
        STREAM:  if (underrun) state_d = PREFILL;
        default: state_d = IDLE;
      endcase
    end
  end

  // Head is entry 0; the returning word goes to the first slot left free
  // once this cycle's transfer has shifted the buffer.
  always_comb begin
    buf_d      = buf_q;
    inflight_d = pop;
    wr_slot    = occ_q - {1'b0, xfer};
    if (xfer && occ_q == 2'd2) buf_d[0] = buf_q[1];
    if (inflight_q) begin
      if (wr_slot[0]) buf_d[1] = bus.FifoQ;
      else            buf_d[0] = bus.FifoQ;
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, xfer};
  end

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge RdClock or posedge RPReset) begin
    if (RPReset) begin
      state_q    <= IDLE;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      buf_q      <= '0;
      ucnt_q     <= 16'd0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      buf_q      <= buf_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign bus.FifoRdEn    = pop;
  assign bus.OutData     = buf_q[0];
  assign bus.OutValid    = (occ_q != 2'd0);
  assign bus.Underrun    = underrun;
  assign bus.UnderrunCnt = ucnt_q;
  assign bus.State       = state_q;
endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: behavioural FIFO model feeding the DUT, scoreboard
// of pushed words checked at every transfer, vector table plus corner sequences.
module tb_fifo_rd_streamer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_streamer_if #(.DSIZE(32), .ASIZE(6)) ifc ();

  fifo_rd_streamer #(.DSIZE(32), .ASIZE(6), .START_LVL(16)) dut (
    .RdClock (clk),
    .RPReset (rst),
    .bus     (ifc)
  );

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endfunction

  // FIFO model with registered Empty / fill level; ovr fakes a "level met but empty" FIFO
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  logic [31:0] word_ctr = 32'd0;
  logic        m_empty = 1'b1;
  logic [6:0]  m_num = 7'd0;
  logic        ovr = 1'b0;
  int          underflow = 0;

  always @(posedge clk) begin
    if (ifc.FifoRdEn) begin
      if (fq.size() > 0) ifc.FifoQ <= fq.pop_front();
      else underflow++;
    end
    m_empty <= (fq.size() == 0);
    m_num   <= 7'(fq.size());
  end
  assign ifc.FifoEmpty     = ovr ? 1'b1  : m_empty;
  assign ifc.FifoRdDataNum = ovr ? 7'd16 : m_num;

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(word_ctr);
      exp_q.push_back(word_ctr);
      word_ctr = word_ctr + 32'd1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops on transfer, stall stability, protocol counters
  int          cyc = 0;
  int          n_xfer = 0, last_xfer = -1, gaps = 0;
  int          ur_pulses = 0, ur_sat_pulses = 0, bad_rden = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_data = 32'd0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(ifc.OutValid), 32'd1);
        chk("stall_data", ifc.OutData, prev_data);
      end
      if (ifc.OutValid && ifc.OutReady) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_unexpected: got %0h want no transfer", ifc.OutData);
        end else begin
          chk("sb_data", ifc.OutData, exp_q.pop_front());
        end
        if (last_xfer >= 0 && cyc != last_xfer + 1) gaps++;
        last_xfer = cyc;
      end
      stall_prev = ifc.OutValid & ~ifc.OutReady;
      prev_data  = ifc.OutData;
      if (ifc.Underrun) begin
        ur_pulses++;
        if (ifc.UnderrunCnt == 16'hFFFF) ur_sat_pulses++;
      end
      if (ifc.FifoRdEn && ifc.State != 2'd2) bad_rden++;
    end
  end

  typedef struct {
    int          push;
    logic        rdy;
    int          wait_cyc;
    logic [1:0]  exp_state;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] exp_ucnt;
  int          p0, first_rd, first_v, pushed;
  bit          seen;

  initial begin
    tbl[0] = '{push: 15, rdy: 1'b1, wait_cyc: 8,  exp_state: 2'd1, exp_cnt: 16'd0}; // below level
    tbl[1] = '{push: 1,  rdy: 1'b0, wait_cyc: 8,  exp_state: 2'd2, exp_cnt: 16'd0}; // level met, stalled
    tbl[2] = '{push: 0,  rdy: 1'b1, wait_cyc: 30, exp_state: 2'd1, exp_cnt: 16'd1}; // drain -> underrun
    tbl[3] = '{push: 32, rdy: 1'b1, wait_cyc: 60, exp_state: 2'd1, exp_cnt: 16'd2};
    tbl[4] = '{push: 20, rdy: 1'b0, wait_cyc: 10, exp_state: 2'd2, exp_cnt: 16'd2};
    tbl[5] = '{push: 0,  rdy: 1'b1, wait_cyc: 40, exp_state: 2'd1, exp_cnt: 16'd3};

    ifc.Enable   = 1'b0;
    ifc.OutReady = 1'b0;
    tick(3);
    chk("rst_state",    32'(ifc.State), 32'd0);
    chk("rst_valid",    32'(ifc.OutValid), 32'd0);
    chk("rst_rden",     32'(ifc.FifoRdEn), 32'd0);
    chk("rst_data",     ifc.OutData, 32'd0);
    chk("rst_underrun", 32'(ifc.Underrun), 32'd0);
    chk("rst_cnt",      32'(ifc.UnderrunCnt), 32'd0);
    rst = 1'b0;
    ifc.Enable = 1'b1;
    tick(2);
    chk("idle_to_prefill", 32'(ifc.State), 32'd1);

    for (int t = 0; t < 6; t++) begin
      ifc.OutReady = tbl[t].rdy;
      push_words(tbl[t].push);
      tick(tbl[t].wait_cyc);
      @(negedge clk);
      chk($sformatf("vec%0d_state", t), 32'(ifc.State), 32'(tbl[t].exp_state));
      chk($sformatf("vec%0d_cnt", t), 32'(ifc.UnderrunCnt), 32'(tbl[t].exp_cnt));
    end
    exp_ucnt = 16'd3;

    // 32 words back to back: 2-cycle pop-to-valid, no gaps, one underrun
    @(posedge clk); #1;
    ifc.OutReady = 1'b1;
    gaps = 0; last_xfer = -1; p0 = ur_pulses; first_rd = -1; first_v = -1;
    pushed = n_xfer;
    push_words(32);
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (first_rd < 0 && ifc.FifoRdEn) first_rd = i;
      if (first_v < 0 && ifc.OutValid) first_v = i;
    end
    exp_ucnt++;
    chk("t2_rd_seen",  32'(first_rd >= 0), 32'd1);
    chk("t2_latency",  32'(first_v - first_rd), 32'd2);
    chk("t2_count",    32'(n_xfer - pushed), 32'd32);
    chk("t2_gaps",     32'(gaps), 32'd0);
    chk("t2_pulses",   32'(ur_pulses - p0), 32'd1);
    chk("t2_cnt",      32'(ifc.UnderrunCnt), 32'(exp_ucnt));
    chk("t2_state",    32'(ifc.State), 32'd1);

    // 1000 words, random OutReady, FIFO kept topped up so it never runs dry
    p0 = ur_pulses; pushed = 0;
    for (int c = 0; c < 20000 && (pushed < 1000 || exp_q.size() > 0); c++) begin
      @(posedge clk); #1;
      ifc.OutReady = 1'($urandom_range(0, 1));
      if (pushed < 1000 && fq.size() < 48) begin
        push_words(1);
        pushed++;
      end
    end
    chk("t3_drained", 32'(exp_q.size()), 32'd0);
    ifc.OutReady = 1'b1;
    tick(6);
    exp_ucnt++;
    @(negedge clk);
    chk("t3_pulses", 32'(ur_pulses - p0), 32'd1);
    chk("t3_cnt",    32'(ifc.UnderrunCnt), 32'(exp_ucnt));

    // Enable dropped while a popped word is in flight
    p0 = ur_pulses; seen = 0;
    push_words(24);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (ifc.State == 2'd2 && ifc.FifoRdEn) seen = 1;
    end
    chk("t4_stream_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    ifc.Enable = 1'b0;
    @(negedge clk);
    chk("t4_rden_off", 32'(ifc.FifoRdEn), 32'd0);
    @(negedge clk);
    chk("t4_idle", 32'(ifc.State), 32'd0);
    tick(12);
    chk("t4_inflight_emitted", 32'(exp_q.size()), 32'(fq.size()));
    chk("t4_no_underrun", 32'(ur_pulses - p0), 32'd0);
    ifc.Enable = 1'b1;
    @(posedge clk); #1;
    chk("t4_reenable", 32'(ifc.State), 32'd1);
    tick(60);
    exp_ucnt++;
    chk("t4_cnt", 32'(ifc.UnderrunCnt), 32'(exp_ucnt));

    // Reset with a full, stalled buffer
    ifc.OutReady = 1'b0;
    push_words(20);
    tick(12);
    chk("t5_pre_valid", 32'(ifc.OutValid), 32'd1);
    chk("t5_pre_cnt",   32'(ifc.UnderrunCnt), 32'(exp_ucnt));
    rst = 1'b1;
    fq.delete();
    exp_q.delete();
    #1;
    chk("t5_valid", 32'(ifc.OutValid), 32'd0);
    chk("t5_state", 32'(ifc.State), 32'd0);
    chk("t5_cnt",   32'(ifc.UnderrunCnt), 32'd0);
    tick(2);
    rst = 1'b0;
    ifc.OutReady = 1'b1;
    tick(3);

    // Saturation: preload near the top, then fake back-to-back underruns
    @(negedge clk);
    force dut.ucnt_q = 16'hFFFB;
    #1;
    release dut.ucnt_q;
    #1;
    chk("t6_preload", 32'(ifc.UnderrunCnt), 32'h0000_FFFB);
    p0 = ur_pulses;
    @(posedge clk); #1;
    ovr = 1'b1;
    tick(20);
    ovr = 1'b0;
    tick(3);
    chk("t6_sat_cnt",   32'(ifc.UnderrunCnt), 32'h0000_FFFF);
    chk("t6_pulses",    32'(ur_pulses - p0 >= 8), 32'd1);
    chk("t6_sat_pulse", 32'(ur_sat_pulses > 0), 32'd1);

    chk("no_pop_outside_stream", 32'(bad_rden), 32'd0);
    chk("fifo_underflow",        32'(underflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
